// File: rtl/gin_stream_controller.sv
// gin_stream_controller: walks a 4-D loop nest over the GLB, packs PACK consecutive
// GLB words into one output word and streams the words, each with a row/column tag,
// into the GIN and tag FIFOs.
//
// Ports
//   clk, reset (async, active-low)
//   start, dim4..dim1, base_addr, col_major, row_tag_max, col_tag_max : stream config, latched
//                                                                       when start is seen in IDLE
//   addr, re_from_glb, din          : GLB read port (din valid one cycle after re_from_glb)
//   gin_fifo_full, we_to_gin_fifo, dout              : packed data output
//   tags_fifo_full, we_to_tags_fifo, row_tag, col_tag : tag output
//   busy, done                      : status (done is a one-cycle pulse)
module gin_stream_controller #(
  parameter int unsigned DIM_WIDTH     = 6,
  parameter int unsigned ADDR_WIDTH    = 20,
  parameter int unsigned IN_WIDTH      = 16,
  parameter int unsigned PACK          = 4,
  parameter int unsigned COLLECT_DEPTH = 4,
  parameter int unsigned ROW_TAG_WIDTH = 4,
  parameter int unsigned COL_TAG_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [DIM_WIDTH-1:0]     dim4,
  input  logic [DIM_WIDTH-1:0]     dim3,
  input  logic [DIM_WIDTH-1:0]     dim2,
  input  logic [DIM_WIDTH-1:0]     dim1,
  input  logic [ADDR_WIDTH-1:0]    base_addr,
  input  logic                     col_major,
  input  logic [ROW_TAG_WIDTH-1:0] row_tag_max,
  input  logic [COL_TAG_WIDTH-1:0] col_tag_max,
  output logic [ADDR_WIDTH-1:0]    addr,
  output logic                     re_from_glb,
  input  logic [IN_WIDTH-1:0]      din,
  input  logic                     gin_fifo_full,
  output logic                     we_to_gin_fifo,
  output logic [IN_WIDTH*PACK-1:0] dout,
  input  logic                     tags_fifo_full,
  output logic                     we_to_tags_fifo,
  output logic [ROW_TAG_WIDTH-1:0] row_tag,
  output logic [COL_TAG_WIDTH-1:0] col_tag,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned OUT_WIDTH = IN_WIDTH * PACK;
  localparam int unsigned PtrW      = (COLLECT_DEPTH > 1) ? $clog2(COLLECT_DEPTH) : 1;
  localparam int unsigned FillW     = $clog2(PACK + 1);
  localparam int unsigned SlotW     = $clog2(COLLECT_DEPTH * PACK + 1) + 1;
  localparam logic [PtrW:0] PtrInc  = 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                   state_q;
  logic [DIM_WIDTH-1:0]     dim4_q, dim3_q, dim2_q, dim1_q;
  logic [DIM_WIDTH-1:0]     idx4_q, idx3_q, idx2_q, idx1_q;
  logic [ADDR_WIDTH-1:0]    base_q;
  logic                     col_major_q;
  logic [ROW_TAG_WIDTH-1:0] row_max_q, row_tag_q;
  logic [COL_TAG_WIDTH-1:0] col_max_q, col_tag_q;
  logic                     inflight_q;
  logic [FillW-1:0]         pack_fill_q, pack_fill_d;
  logic [OUT_WIDTH-1:0]     pack_data_q, pack_data_d, pack_with;
  logic [OUT_WIDTH-1:0]     mem [COLLECT_DEPTH];
  logic [PtrW:0]            wr_ptr_q, rd_ptr_q, count;
  logic                     coll_empty, coll_full, coll_wr, coll_wr_ok;
  logic [OUT_WIDTH-1:0]     coll_wdata;
  logic [SlotW-1:0]         used;
  logic                     push, last1, last2, last3, last4, any_zero;

  // Address generation, truncated to ADDR_WIDTH
  logic [ADDR_WIDTH-1:0] a1, a2, a3, a4, d1, d2, d3, d4;
  assign a1 = ADDR_WIDTH'(idx1_q);
  assign a2 = ADDR_WIDTH'(idx2_q);
  assign a3 = ADDR_WIDTH'(idx3_q);
  assign a4 = ADDR_WIDTH'(idx4_q);
  assign d1 = ADDR_WIDTH'(dim1_q);
  assign d2 = ADDR_WIDTH'(dim2_q);
  assign d3 = ADDR_WIDTH'(dim3_q);
  assign d4 = ADDR_WIDTH'(dim4_q);
  assign addr = col_major_q ? base_q + ((a1 * d2 + a2) * d3 + a3) * d4 + a4
                            : base_q + ((a4 * d3 + a3) * d2 + a2) * d1 + a1;

  // Element slots are reserved at read issue so the collector can never overflow.
  assign count      = wr_ptr_q - rd_ptr_q;
  assign coll_empty = (count == '0);
  assign coll_full  = (count == (PtrW + 1)'(COLLECT_DEPTH));
  assign used       = SlotW'(count) * SlotW'(PACK) + SlotW'(pack_fill_q) + SlotW'(inflight_q);
  assign re_from_glb = (state_q == StRun) && (used < SlotW'(COLLECT_DEPTH * PACK));

  assign push            = !coll_empty && !gin_fifo_full && !tags_fifo_full;
  assign we_to_gin_fifo  = push;
  assign we_to_tags_fifo = push;
  assign dout            = coll_empty ? '0 : mem[rd_ptr_q[PtrW-1:0]];
  assign row_tag         = row_tag_q;
  assign col_tag         = col_tag_q;
  assign busy            = (state_q == StRun) || (state_q == StDrain);
  assign done            = (state_q == StDone);

  assign last1    = (idx1_q == dim1_q - DIM_WIDTH'(1));
  assign last2    = (idx2_q == dim2_q - DIM_WIDTH'(1));
  assign last3    = (idx3_q == dim3_q - DIM_WIDTH'(1));
  assign last4    = (idx4_q == dim4_q - DIM_WIDTH'(1));
  assign any_zero = (dim1 == '0) || (dim2 == '0) || (dim3 == '0) || (dim4 == '0);

  // Packer: capture returning data; in DRAIN flush a zero-padded partial group.
  always_comb begin
    pack_with = pack_data_q;
    pack_with[pack_fill_q * IN_WIDTH +: IN_WIDTH] = din;
    pack_fill_d = pack_fill_q;
    pack_data_d = pack_data_q;
    coll_wr     = 1'b0;
    coll_wdata  = pack_with;
    if (inflight_q) begin
      if (pack_fill_q == FillW'(PACK - 1)) begin
        coll_wr     = 1'b1;
        pack_fill_d = '0;
        pack_data_d = '0;
      end else begin
        pack_fill_d = pack_fill_q + FillW'(1);
        pack_data_d = pack_with;
      end
    end else if (state_q == StDrain && pack_fill_q != '0) begin
      coll_wr     = 1'b1;
      coll_wdata  = pack_data_q;
      pack_fill_d = '0;
      pack_data_d = '0;
    end
  end

  // A full collector may still accept a word when its head leaves the same cycle.
  assign coll_wr_ok = coll_wr && (!coll_full || push);

  always_ff @(posedge clk) begin
    if (coll_wr_ok) mem[wr_ptr_q[PtrW-1:0]] <= coll_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      dim4_q      <= '0;
      dim3_q      <= '0;
      dim2_q      <= '0;
      dim1_q      <= '0;
      idx4_q      <= '0;
      idx3_q      <= '0;
      idx2_q      <= '0;
      idx1_q      <= '0;
      base_q      <= '0;
      col_major_q <= 1'b0;
      row_max_q   <= '0;
      col_max_q   <= '0;
      row_tag_q   <= '0;
      col_tag_q   <= '0;
      inflight_q  <= 1'b0;
      pack_fill_q <= '0;
      pack_data_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      inflight_q  <= re_from_glb;
      pack_fill_q <= pack_fill_d;
      pack_data_q <= pack_data_d;
      if (coll_wr_ok) wr_ptr_q <= wr_ptr_q + PtrInc;
      if (push)       rd_ptr_q <= rd_ptr_q + PtrInc;

      if (push) begin
        if (col_tag_q == col_max_q) begin
          col_tag_q <= '0;
          row_tag_q <= (row_tag_q == row_max_q) ? '0 : row_tag_q + ROW_TAG_WIDTH'(1);
        end else begin
          col_tag_q <= col_tag_q + COL_TAG_WIDTH'(1);
        end
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            dim4_q      <= dim4;
            dim3_q      <= dim3;
            dim2_q      <= dim2;
            dim1_q      <= dim1;
            base_q      <= base_addr;
            col_major_q <= col_major;
            row_max_q   <= row_tag_max;
            col_max_q   <= col_tag_max;
            idx4_q      <= '0;
            idx3_q      <= '0;
            idx2_q      <= '0;
            idx1_q      <= '0;
            row_tag_q   <= '0;
            col_tag_q   <= '0;
            state_q     <= any_zero ? StDone : StRun;
          end
        end
        StRun: begin
          if (re_from_glb) begin
            // Odometer: idx1 innermost, carry outward on wrap
            idx1_q <= last1 ? '0 : idx1_q + DIM_WIDTH'(1);
            if (last1) begin
              idx2_q <= last2 ? '0 : idx2_q + DIM_WIDTH'(1);
              if (last2) begin
                idx3_q <= last3 ? '0 : idx3_q + DIM_WIDTH'(1);
                if (last3) idx4_q <= last4 ? '0 : idx4_q + DIM_WIDTH'(1);
              end
            end
            if (last1 && last2 && last3 && last4) state_q <= StDrain;
          end
        end
        StDrain: begin
          if (!inflight_q && pack_fill_q == '0 && coll_empty) state_q <= StDone;
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_gin_stream_controller.sv
module tb_gin_stream_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  dim4 = '0, dim3 = '0, dim2 = '0, dim1 = '0;
  logic [19:0] base_addr = '0;
  logic        col_major = 1'b0;
  logic [3:0]  row_tag_max = '0, col_tag_max = '0;
  logic [19:0] addr;
  logic        re_from_glb;
  logic [15:0] din = '0;
  logic        gin_fifo_full = 1'b0;
  logic        we_to_gin_fifo;
  logic [63:0] dout;
  logic        tags_fifo_full = 1'b0;
  logic        we_to_tags_fifo;
  logic [3:0]  row_tag, col_tag;
  logic        busy, done;

  int checks = 0;
  int errors = 0;
  int reads = 0;
  int pushes = 0;
  int dones = 0;

  logic [19:0] exp_addr_q[$];
  logic [63:0] exp_word_q[$];
  logic [7:0]  exp_tag_q[$];

  gin_stream_controller dut (
    .clk(clk), .reset(reset), .start(start),
    .dim4(dim4), .dim3(dim3), .dim2(dim2), .dim1(dim1),
    .base_addr(base_addr), .col_major(col_major),
    .row_tag_max(row_tag_max), .col_tag_max(col_tag_max),
    .addr(addr), .re_from_glb(re_from_glb), .din(din),
    .gin_fifo_full(gin_fifo_full), .we_to_gin_fifo(we_to_gin_fifo), .dout(dout),
    .tags_fifo_full(tags_fifo_full), .we_to_tags_fifo(we_to_tags_fifo),
    .row_tag(row_tag), .col_tag(col_tag), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] glb_f(input logic [19:0] a);
    return a[15:0] ^ 16'h5A3C;
  endfunction

  // GLB model: data for the address read this cycle appears on din next cycle
  always @(posedge clk) din <= glb_f(addr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer
  always @(negedge clk) begin
    if (reset) begin
      if (re_from_glb) begin
        reads++;
        if (exp_addr_q.size() == 0) chk("unexpected_read", 64'd1, 64'd0);
        else chk("addr", {44'd0, addr}, {44'd0, exp_addr_q.pop_front()});
      end
      if (gin_fifo_full || tags_fifo_full) chk("push_while_full", {63'd0, we_to_gin_fifo}, 64'd0);
      if (we_to_gin_fifo) begin
        pushes++;
        chk("we_tags", {63'd0, we_to_tags_fifo}, 64'd1);
        if (exp_word_q.size() == 0) chk("unexpected_push", 64'd1, 64'd0);
        else begin
          chk("dout", dout, exp_word_q.pop_front());
          chk("tags", {56'd0, row_tag, col_tag}, {56'd0, exp_tag_q.pop_front()});
        end
      end
      if (done) dones++;
    end
  end

  // Reference model: expected addresses, packed words and tags for one stream
  task automatic build(input int d4, input int d3, input int d2, input int d1,
                       input logic [19:0] base, input logic cm,
                       input logic [3:0] rtm, input logic [3:0] ctm);
    int e;
    logic [63:0] w;
    logic [19:0] a;
    logic [3:0] r, c;
    exp_addr_q.delete();
    exp_word_q.delete();
    exp_tag_q.delete();
    e = 0; w = '0; r = '0; c = '0;
    for (int i4 = 0; i4 < d4; i4++)
      for (int i3 = 0; i3 < d3; i3++)
        for (int i2 = 0; i2 < d2; i2++)
          for (int i1 = 0; i1 < d1; i1++) begin
            if (cm) a = base + 20'(((i1 * d2 + i2) * d3 + i3) * d4 + i4);
            else    a = base + 20'(((i4 * d3 + i3) * d2 + i2) * d1 + i1);
            exp_addr_q.push_back(a);
            w[(e % 4) * 16 +: 16] = glb_f(a);
            e++;
            if (e % 4 == 0) begin
              exp_word_q.push_back(w);
              exp_tag_q.push_back({r, c});
              if (c == ctm) begin c = '0; r = (r == rtm) ? 4'd0 : r + 4'd1; end
              else c = c + 4'd1;
              w = '0;
            end
          end
    if (e % 4 != 0) begin
      exp_word_q.push_back(w);
      exp_tag_q.push_back({r, c});
    end
  endtask

  task automatic run_stream(input int d4, input int d3, input int d2, input int d1,
                            input logic [19:0] base, input logic cm,
                            input logic [3:0] rtm, input logic [3:0] ctm, input int bp);
    int r0, p0, dn0, n, got;
    n = d4 * d3 * d2 * d1;
    build(d4, d3, d2, d1, base, cm, rtm, ctm);
    r0 = reads; p0 = pushes; dn0 = dones;
    @(posedge clk); #1;
    dim4 = 6'(d4); dim3 = 6'(d3); dim2 = 6'(d2); dim1 = 6'(d1);
    base_addr = base; col_major = cm; row_tag_max = rtm; col_tag_max = ctm;
    gin_fifo_full = (bp > 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (bp > 0) begin
      repeat (bp) @(posedge clk);
      #1;
      chk("stall_reads", 64'(reads - r0), 64'd16);
      chk("stall_pushes", 64'(pushes - p0), 64'd0);
      chk("stall_busy", {63'd0, busy}, 64'd1);
      gin_fifo_full = 1'b0;
    end
    got = 0;
    for (int i = 0; i < 3000 && got == 0; i++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    chk("done_seen", 64'(got), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("reads", 64'(reads - r0), 64'(n));
    chk("pushes", 64'(pushes - p0), 64'((n + 3) / 4));
    chk("done_pulses", 64'(dones - dn0), 64'd1);
    chk("addr_left", 64'(exp_addr_q.size()), 64'd0);
    chk("word_left", 64'(exp_word_q.size()), 64'd0);
    chk("busy_after", {63'd0, busy}, 64'd0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_addr"}, {44'd0, addr}, 64'd0);
    chk({tag, "_re"}, {63'd0, re_from_glb}, 64'd0);
    chk({tag, "_we"}, {62'd0, we_to_gin_fifo, we_to_tags_fifo}, 64'd0);
    chk({tag, "_dout"}, dout, 64'd0);
    chk({tag, "_tags"}, {56'd0, row_tag, col_tag}, 64'd0);
    chk({tag, "_busy_done"}, {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    int r0, dn0;
    #2;
    chk_outputs_zero("reset");
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    run_stream(1, 1, 2, 4, 20'h00100, 1'b0, 4'd15, 4'd15, 0);  // basic, 0x100..0x107
    run_stream(1, 1, 1, 6, 20'h00200, 1'b0, 4'd15, 4'd15, 0);  // zero-padded tail
    run_stream(1, 1, 2, 3, 20'h00000, 1'b1, 4'd15, 4'd15, 0);  // col-major 0,2,4,1,3,5
    run_stream(2, 3, 2, 3, 20'h01000, 1'b1, 4'd15, 4'd15, 0);  // col-major, all dims
    run_stream(1, 2, 2, 4, 20'hFFFFC, 1'b0, 4'd15, 4'd15, 0);  // address wrap
    run_stream(1, 1, 4, 16, 20'h03000, 1'b0, 4'd15, 4'd15, 40); // backpressure
    run_stream(1, 1, 1, 28, 20'h04000, 1'b0, 4'd1, 4'd2, 0);   // tag wrap, 7 pushes

    // Reset mid-RUN
    build(1, 1, 4, 16, 20'h00040, 1'b0, 4'd15, 4'd15);
    @(posedge clk); #1;
    dim4 = 6'd1; dim3 = 6'd1; dim2 = 6'd4; dim1 = 6'd16;
    base_addr = 20'h00040; col_major = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    chk("mid_run_busy", {63'd0, busy}, 64'd1);
    reset = 1'b0;
    #1;
    chk_outputs_zero("mid_reset");
    exp_addr_q.delete();
    exp_word_q.delete();
    exp_tag_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    r0 = reads;
    repeat (5) begin
      @(negedge clk);
      chk("no_read_after_reset", {63'd0, re_from_glb}, 64'd0);
    end

    // Zero dimension: done next cycle, no reads
    @(posedge clk); #1;
    dim1 = 6'd0;
    dn0 = dones;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("zero_dim_done", {62'd0, done, busy}, 64'd2);
    @(negedge clk);
    chk("zero_dim_done_clear", {63'd0, done}, 64'd0);
    chk("zero_dim_reads", 64'(reads - r0), 64'd0);
    chk("zero_dim_pulses", 64'(dones - dn0), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gin_stream_controller.md
GIN_STREAM_CONTROLLER -- requirements
Module: gin_stream_controller

Interface
REQ-001 SHALL have parameter DIM_WIDTH, default 6, bit width of each loop-dimension count.
REQ-002 SHALL have parameter ADDR_WIDTH, default 20, GLB address width.
REQ-003 SHALL have parameter IN_WIDTH, default 16, GLB word width.
REQ-004 SHALL have parameter PACK, default 4, GLB words per packed output word; OUT_WIDTH = IN_WIDTH*PACK.
REQ-005 SHALL have parameter COLLECT_DEPTH, default 4, collector capacity in packed words; power of 2, at least 2.
REQ-006 SHALL have parameters ROW_TAG_WIDTH and COL_TAG_WIDTH, default 4 each.
REQ-007 SHALL have ports as listed:
- clk, in, 1: single clock; all state on rising edge.
- reset, in, 1: asynchronous, active-low (0 = reset).
- start, in, 1: launch stream; sampled only in IDLE.
- dim4, dim3, dim2, dim1, in, DIM_WIDTH each: loop counts, outer to inner; latched at start.
- base_addr, in, ADDR_WIDTH: latched at start.
- col_major, in, 1: address mapping mode; latched at start.
- row_tag_max, in, ROW_TAG_WIDTH: row tag wrap value; latched at start.
- col_tag_max, in, COL_TAG_WIDTH: column tag wrap value; latched at start.
- addr, out, ADDR_WIDTH: GLB read address.
- re_from_glb, out, 1: GLB read strobe.
- din, in, IN_WIDTH: GLB data, valid one cycle after re_from_glb.
- gin_fifo_full, in, 1: backpressure from the GIN FIFO.
- we_to_gin_fifo, out, 1: GIN FIFO write strobe.
- dout, out, OUT_WIDTH: packed data to the GIN FIFO.
- tags_fifo_full, in, 1: backpressure from the tag FIFO.
- we_to_tags_fifo, out, 1: tag FIFO write strobe.
- row_tag, out, ROW_TAG_WIDTH: row tag for the current push.
- col_tag, out, COL_TAG_WIDTH: column tag for the current push.
- busy, out, 1: high in RUN and DRAIN.
- done, out, 1: one-cycle completion pulse.

Function
REQ-008 SHALL use FSM states IDLE, RUN, DRAIN, DONE; IDLE->RUN on start when all dims are nonzero; IDLE->DONE on start when any dim is 0; RUN->DRAIN after the last read issues; DRAIN->DONE when no read is in flight, the packer has been flushed and the collector is empty; DONE->IDLE unconditionally.
REQ-009 SHALL pulse done only in DONE, for one cycle; start in any other state SHALL be ignored.
REQ-010 SHALL traverse indices idx4, idx3, idx2, idx1, each counting from 0 to dim-1, with idx1 innermost; an index SHALL advance only on a cycle where re_from_glb=1, carrying outward on wrap.
REQ-011 SHALL drive addr, when col_major=0, as base + ((idx4*dim3 + idx3)*dim2 + idx2)*dim1 + idx1.
REQ-012 SHALL drive addr, when col_major=1, as base + ((idx1*dim2 + idx2)*dim3 + idx3)*dim4 + idx4.
REQ-013 SHALL compute addr modulo 2^ADDR_WIDTH; addr SHALL be combinational from the current indices.
REQ-014 SHALL assert re_from_glb only in RUN, and only when free element slots remain: COLLECT_DEPTH*PACK - (collector_count*PACK + pack_fill + inflight) > 0.
REQ-015 SHALL capture din the cycle after each read; the k-th element of a group SHALL occupy bits [k*IN_WIDTH +: IN_WIDTH], with the first element in the LSBs.
REQ-016 SHALL push the packed word into the collector when pack_fill reaches PACK.
REQ-017 SHALL, in DRAIN, zero-pad any partial group (pack_fill > 0) and push it as one word; the total number of pushes SHALL equal ceil(N/PACK), where N = dim4*dim3*dim2*dim1.
REQ-018 SHALL drive we_to_gin_fifo = we_to_tags_fifo = (collector not empty) & ~gin_fifo_full & ~tags_fifo_full; dout SHALL present the collector head.
REQ-019 SHALL handle a collector write and read in the same cycle correctly, including when the collector is full (no data loss) or empty (no read).
REQ-020 SHALL start tags at 0 on start and advance them once per push: col_tag increments; at col_tag_max it wraps to 0 and row_tag increments; at row_tag_max row_tag wraps to 0.
REQ-021 SHALL output, on each push, the tags associated with that push.

Reset
REQ-022 SHALL, on reset=0, asynchronously clear: FSM to IDLE, all indices, pack_fill, inflight, collector pointers, tags, and latched config.
REQ-023 SHALL hold all outputs at 0 during reset, including mid-stream; in-flight data SHALL be discarded.
REQ-024 SHALL require a fresh start after reset deassertion before any read.

Verification
REQ-025 dims 1,1,2,4, PACK=4, base 0x100, no backpressure -> addr sequence 0x100-0x107, two pushes, done pulses once.
REQ-026 dims 1,1,1,6, PACK=4 -> second push is {0,0,d5,d4}; 2 pushes total.
REQ-027 dims 1,1,2,3, col_major=1, base 0 -> addr sequence 0,2,4,1,3,5.
REQ-028 gin_fifo_full held for 40 cycles, N=64 -> reads stall at COLLECT_DEPTH*PACK outstanding elements; no push while full; no data lost after release.
REQ-029 col_tag_max=2, row_tag_max=1, 7 pushes -> (row,col) sequence (0,0)(0,1)(0,2)(1,0)(1,1)(1,2)(0,0).
REQ-030 reset=0 asserted mid-RUN -> outputs go to 0 immediately; dim1=0 with start -> done the next cycle with zero reads.
